// File: rtl/cga_io_regs.sv
// CGA/Tandy I/O register block: ISA decode, mode/colour/gate-array registers, status, blink, memory wait-states.
// Define CGA_PCJR_FLIPFLOP_EN for PCjr addressing (base+A alternates index/data); default is Tandy 1000 addressing.
module cga_io_regs #(
    parameter logic [15:0] IO_BASE_ADDR  = 16'h3D0,
    parameter int          PALETTE_DEPTH = 16,
    parameter int          WAIT_CYCLES   = 0,
    parameter logic [23:0] BLINK_MAX     = 24'd0
) (
    input  logic        clk,
    input  logic        reset_l,
    input  logic [14:0] bus_a,
    input  logic [7:0]  bus_d,
    input  logic        bus_aen,
    input  logic        bus_ior_l,
    input  logic        bus_iow_l,
    input  logic        bus_memr_l,
    input  logic        bus_memw_l,
    input  logic        bus_mem_cs,
    input  logic        vsync,
    input  logic        display_enable,
    input  logic        blink_hold,
    input  logic [3:0]  pal_idx,
    output logic [7:0]  bus_out,
    output logic        bus_dir,
    output logic        bus_rdy,
    output logic [7:0]  control_reg,
    output logic [7:0]  color_reg,
    output logic [3:0]  pal_mask,
    output logic [3:0]  border_col,
    output logic [3:0]  tandy_mode,
    output logic [3:0]  pal_color,
    output logic        pal_write,
    output logic        blink
);

    localparam logic [14:0] A_CTRL  = IO_BASE_ADDR[14:0] + 15'h8;
    localparam logic [14:0] A_COLOR = IO_BASE_ADDR[14:0] + 15'h9;
    localparam logic [14:0] A_STAT  = IO_BASE_ADDR[14:0] + 15'hA;
    localparam logic [14:0] A_DATA  = IO_BASE_ADDR[14:0] + 15'hE;
    localparam logic [3:0]  WAIT_LAST = 4'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_HOLD} wait_state_t;

    logic iow_s1, iow_s2, iow_s3;
    logic memr_s1, memr_s2, memw_s1, memw_s2, mem_idle_d;
    logic vsync_s1, vsync_s, de_s1, de_s;
    logic mem_idle_s, wr_stb, io_wr, mem_edge;
    logic idx_wr, ga_wr, pal_hit;
    logic [4:0]  idx;
    logic [3:0]  pal [PALETTE_DEPTH];
    logic [23:0] blink_cnt;
    logic [3:0]  wait_cnt;
    wait_state_t state, next_state;

    // Synchronisers are left unreset so they keep tracking the bus during reset;
    // a strobe already low when reset lifts therefore never looks like a new edge.
    always_ff @(posedge clk) begin
        iow_s1     <= bus_iow_l;
        iow_s2     <= iow_s1;
        iow_s3     <= iow_s2;
        memr_s1    <= bus_memr_l;
        memr_s2    <= memr_s1;
        memw_s1    <= bus_memw_l;
        memw_s2    <= memw_s1;
        mem_idle_d <= mem_idle_s;
        vsync_s1   <= vsync;
        vsync_s    <= vsync_s1;
        de_s1      <= display_enable;
        de_s       <= de_s1;
    end

    assign mem_idle_s = memr_s2 & memw_s2;
    assign wr_stb     = iow_s3 & ~iow_s2;
    assign io_wr      = wr_stb & ~bus_aen;
    assign mem_edge   = mem_idle_d & ~mem_idle_s & bus_mem_cs;
    assign pal_hit    = idx[4] && (int'(idx[3:0]) < PALETTE_DEPTH);

`ifdef CGA_PCJR_FLIPFLOP_EN
    logic ior_s1, ior_s2, ior_s3, flip, rd_stat_edge;

    always_ff @(posedge clk) begin
        ior_s1 <= bus_ior_l;
        ior_s2 <= ior_s1;
        ior_s3 <= ior_s2;
    end

    assign rd_stat_edge = ior_s3 & ~ior_s2 & ~bus_aen & (bus_a == A_STAT);

    // flip = 0 means the next base+A write is an index, 1 means it is data
    always_ff @(posedge clk) begin
        if (!reset_l)
            flip <= 1'b0;
        else if (io_wr && (bus_a == A_STAT))
            flip <= ~flip;
        else if (rd_stat_edge)
            flip <= 1'b0;
    end

    assign idx_wr = io_wr & (bus_a == A_STAT) & ~flip;
    assign ga_wr  = io_wr & (bus_a == A_STAT) & flip;
`else
    assign idx_wr = io_wr & (bus_a == A_STAT);
    assign ga_wr  = io_wr & (bus_a == A_DATA);
`endif

    always_ff @(posedge clk) begin
        if (!reset_l) begin
            control_reg <= 8'h29;
            color_reg   <= 8'h00;
            pal_mask    <= 4'hF;
            border_col  <= 4'h0;
            tandy_mode  <= 4'h0;
            idx         <= 5'h00;
            pal_write   <= 1'b0;
            for (int i = 0; i < PALETTE_DEPTH; i++)
                pal[i] <= 4'(i);
        end else begin
            pal_write <= ga_wr & pal_hit;
            if (io_wr && (bus_a == A_CTRL))
                control_reg <= bus_d;
            if (io_wr && (bus_a == A_COLOR))
                color_reg <= bus_d;
            if (idx_wr)
                idx <= bus_d[4:0];
            if (ga_wr) begin
                case (idx)
                    5'h01:   pal_mask   <= bus_d[3:0];
                    5'h02:   border_col <= bus_d[3:0];
                    5'h03:   tandy_mode <= bus_d[3:0];
                    default: ;
                endcase
                for (int i = 0; i < PALETTE_DEPTH; i++)
                    if (idx == 5'(16 + i))
                        pal[i] <= bus_d[3:0];
            end
        end
    end

    // Indices beyond the implemented palette pass straight through the mask
    always_comb begin
        pal_color = pal_idx & pal_mask;
        for (int i = 0; i < PALETTE_DEPTH; i++)
            if (pal_idx == 4'(i))
                pal_color = pal[i] & pal_mask;
    end

    always_comb begin
        bus_out = 8'h00;
        bus_dir = 1'b0;
        if (!bus_ior_l && !bus_aen && (bus_a == A_STAT)) begin
            bus_out = {4'b1111, vsync_s, 2'b10, ~de_s};
            bus_dir = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_l) begin
            blink_cnt <= 24'd0;
            blink     <= 1'b0;
        end else if (!blink_hold) begin
            if (blink_cnt == BLINK_MAX) begin
                blink_cnt <= 24'd0;
                blink     <= ~blink;
            end else begin
                blink_cnt <= blink_cnt + 24'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_l) begin
            state    <= ST_IDLE;
            wait_cnt <= 4'd0;
        end else begin
            state    <= next_state;
            wait_cnt <= (state == ST_WAIT) ? wait_cnt + 4'd1 : 4'd0;
        end
    end

    // HOLD ignores fresh edges until the bus cycle has fully ended
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: if (mem_edge && (WAIT_CYCLES > 0)) next_state = ST_WAIT;
            ST_WAIT: if (wait_cnt == WAIT_LAST)         next_state = ST_HOLD;
            ST_HOLD: if (mem_idle_s)                    next_state = ST_IDLE;
            default:                                    next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        bus_rdy = (WAIT_CYCLES == 0) || (state != ST_WAIT);
    end

endmodule

// File: tb/tb_cga_io_regs.sv
// Directed bench for cga_io_regs: depth 12, three wait-states, blink half-period of four clocks.
module tb_cga_io_regs;

    logic        clk = 1'b0;
    logic        reset_l = 1'b0;
    logic [14:0] bus_a = 15'h0;
    logic [7:0]  bus_d = 8'h0;
    logic        bus_aen = 1'b0;
    logic        bus_ior_l = 1'b1, bus_iow_l = 1'b1;
    logic        bus_memr_l = 1'b1, bus_memw_l = 1'b1;
    logic        bus_mem_cs = 1'b0;
    logic        vsync = 1'b0, display_enable = 1'b1;
    logic        blink_hold = 1'b0;
    logic [3:0]  pal_idx = 4'h0;
    logic [7:0]  bus_out, control_reg, color_reg;
    logic        bus_dir, bus_rdy, pal_write, blink;
    logic [3:0]  pal_mask, border_col, tandy_mode, pal_color;

    int checks = 0;
    int errors = 0;
    int pw_count = 0;

    cga_io_regs #(
        .IO_BASE_ADDR(16'h3D0), .PALETTE_DEPTH(12), .WAIT_CYCLES(3), .BLINK_MAX(24'd3)
    ) dut (
        .clk(clk), .reset_l(reset_l), .bus_a(bus_a), .bus_d(bus_d), .bus_aen(bus_aen),
        .bus_ior_l(bus_ior_l), .bus_iow_l(bus_iow_l), .bus_memr_l(bus_memr_l),
        .bus_memw_l(bus_memw_l), .bus_mem_cs(bus_mem_cs), .vsync(vsync),
        .display_enable(display_enable), .blink_hold(blink_hold), .pal_idx(pal_idx),
        .bus_out(bus_out), .bus_dir(bus_dir), .bus_rdy(bus_rdy), .control_reg(control_reg),
        .color_reg(color_reg), .pal_mask(pal_mask), .border_col(border_col),
        .tandy_mode(tandy_mode), .pal_color(pal_color), .pal_write(pal_write), .blink(blink)
    );

    always #5 clk = ~clk;

    always @(negedge clk)
        if (pal_write === 1'b1) pw_count++;

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic io_write(input logic [14:0] a, input logic [7:0] d);
        bus_a = a;
        bus_d = d;
        bus_iow_l = 1'b0;
        repeat (4) tick();
        bus_iow_l = 1'b1;
        repeat (4) tick();
    endtask

    task automatic ga_write(input logic [7:0] index, input logic [7:0] d);
        io_write(15'h3DA, index);
`ifdef CGA_PCJR_FLIPFLOP_EN
        io_write(15'h3DA, d);
`else
        io_write(15'h3DE, d);
`endif
    endtask

    task automatic test_reset();
        reset_l = 1'b0;
        pal_idx = 4'd7;
        repeat (4) tick();
        checks++; if (control_reg !== 8'h29) begin errors++; $display("[TB] FAIL reset_control got %h expected 29", control_reg); end
        checks++; if (color_reg !== 8'h00) begin errors++; $display("[TB] FAIL reset_color got %h expected 00", color_reg); end
        checks++; if (pal_mask !== 4'hF) begin errors++; $display("[TB] FAIL reset_mask got %h expected f", pal_mask); end
        checks++; if ({border_col, tandy_mode} !== 8'h00) begin errors++; $display("[TB] FAIL reset_ga got %h expected 00", {border_col, tandy_mode}); end
        checks++; if (pal_color !== 4'h7) begin errors++; $display("[TB] FAIL reset_pal7 got %h expected 7", pal_color); end
        checks++; if (bus_rdy !== 1'b1) begin errors++; $display("[TB] FAIL reset_rdy got %b expected 1", bus_rdy); end
        checks++; if (blink !== 1'b0) begin errors++; $display("[TB] FAIL reset_blink got %b expected 0", blink); end
        checks++; if (pal_write !== 1'b0) begin errors++; $display("[TB] FAIL reset_palwr got %b expected 0", pal_write); end
        reset_l = 1'b1;
    endtask

    task automatic test_blink();
        reset_l = 1'b0;
        blink_hold = 1'b0;
        tick();
        reset_l = 1'b1;
        repeat (3) tick();
        checks++; if (blink !== 1'b0) begin errors++; $display("[TB] FAIL blink_e3 got %b expected 0", blink); end
        tick();
        checks++; if (blink !== 1'b1) begin errors++; $display("[TB] FAIL blink_e4 got %b expected 1", blink); end
        tick();
        blink_hold = 1'b1;
        repeat (10) tick();
        checks++; if (blink !== 1'b1) begin errors++; $display("[TB] FAIL blink_hold got %b expected 1", blink); end
        blink_hold = 1'b0;
        repeat (2) tick();
        checks++; if (blink !== 1'b1) begin errors++; $display("[TB] FAIL blink_resume got %b expected 1", blink); end
        tick();
        checks++; if (blink !== 1'b0) begin errors++; $display("[TB] FAIL blink_toggle got %b expected 0", blink); end
    endtask

    task automatic test_palette();
        int base;
        base = pw_count;
        ga_write(8'h12, 8'h0C);
        checks++; if (pw_count !== base + 1) begin errors++; $display("[TB] FAIL pal_pulse got %0d expected %0d", pw_count, base + 1); end
        pal_idx = 4'd2;
        #1;
        checks++; if (pal_color !== 4'hC) begin errors++; $display("[TB] FAIL pal2 got %h expected c", pal_color); end
        ga_write(8'h01, 8'h03);
        checks++; if (pal_mask !== 4'h3) begin errors++; $display("[TB] FAIL mask_load got %h expected 3", pal_mask); end
        checks++; if (pal_color !== 4'h0) begin errors++; $display("[TB] FAIL pal2_masked got %h expected 0", pal_color); end
        checks++; if (pw_count !== base + 1) begin errors++; $display("[TB] FAIL mask_nopulse got %0d expected %0d", pw_count, base + 1); end
        ga_write(8'h01, 8'h0F);
        checks++; if (pal_mask !== 4'hF) begin errors++; $display("[TB] FAIL mask_restore got %h expected f", pal_mask); end
    endtask

    task automatic test_depth_boundary();
        int base;
        base = pw_count;
        ga_write(8'h1C, 8'h05);
        checks++; if (pw_count !== base) begin errors++; $display("[TB] FAIL beyond_depth_pulse got %0d expected %0d", pw_count, base); end
        pal_idx = 4'd12;
        #1;
        checks++; if (pal_color !== 4'hC) begin errors++; $display("[TB] FAIL beyond_depth_color got %h expected c", pal_color); end
        ga_write(8'h1B, 8'h09);
        checks++; if (pw_count !== base + 1) begin errors++; $display("[TB] FAIL last_entry_pulse got %0d expected %0d", pw_count, base + 1); end
        pal_idx = 4'd11;
        #1;
        checks++; if (pal_color !== 4'h9) begin errors++; $display("[TB] FAIL last_entry_color got %h expected 9", pal_color); end
        ga_write(8'h04, 8'h0B);
        checks++; if ({pal_mask, border_col, tandy_mode} !== 12'hF00) begin errors++; $display("[TB] FAIL idx04_ignored got %h expected f00", {pal_mask, border_col, tandy_mode}); end
        checks++; if (pw_count !== base + 1) begin errors++; $display("[TB] FAIL idx04_pulse got %0d expected %0d", pw_count, base + 1); end
    endtask

    task automatic test_ga_regs();
        ga_write(8'h02, 8'h06);
        checks++; if (border_col !== 4'h6) begin errors++; $display("[TB] FAIL border got %h expected 6", border_col); end
        ga_write(8'h03, 8'h0A);
        checks++; if (tandy_mode !== 4'hA) begin errors++; $display("[TB] FAIL tandy got %h expected a", tandy_mode); end
    endtask

`ifdef CGA_PCJR_FLIPFLOP_EN
    task automatic test_addressing();
        io_write(15'h3DA, 8'h02);
        io_write(15'h3DA, 8'h05);
        checks++; if (border_col !== 4'h5) begin errors++; $display("[TB] FAIL pcjr_border got %h expected 5", border_col); end
        bus_a = 15'h3DA;
        bus_ior_l = 1'b0;
        repeat (4) tick();
        bus_ior_l = 1'b1;
        repeat (4) tick();
        io_write(15'h3DA, 8'h03);
        io_write(15'h3DA, 8'h01);
        checks++; if (tandy_mode !== 4'h1) begin errors++; $display("[TB] FAIL pcjr_tandy got %h expected 1", tandy_mode); end
        io_write(15'h3DA, 8'h02);
        bus_ior_l = 1'b0;
        repeat (4) tick();
        bus_ior_l = 1'b1;
        repeat (4) tick();
        io_write(15'h3DA, 8'h03);
        io_write(15'h3DA, 8'h07);
        checks++; if ({border_col, tandy_mode} !== 8'h57) begin errors++; $display("[TB] FAIL pcjr_read_clear got %h expected 57", {border_col, tandy_mode}); end
        io_write(15'h3DE, 8'h09);
        checks++; if ({border_col, tandy_mode} !== 8'h57) begin errors++; $display("[TB] FAIL pcjr_3de_ignored got %h expected 57", {border_col, tandy_mode}); end
    endtask
`else
    task automatic test_addressing();
        io_write(15'h3DA, 8'h02);
        io_write(15'h3DA, 8'h03);
        io_write(15'h3DE, 8'h07);
        checks++; if ({border_col, tandy_mode} !== 8'h67) begin errors++; $display("[TB] FAIL tandy_index_only got %h expected 67", {border_col, tandy_mode}); end
    endtask
`endif

    task automatic test_hold_write();
        bus_a = 15'h3D8;
        bus_d = 8'h0A;
        bus_iow_l = 1'b0;
        repeat (2) tick();
        checks++; if (control_reg !== 8'h29) begin errors++; $display("[TB] FAIL hold_edge2 got %h expected 29", control_reg); end
        tick();
        checks++; if (control_reg !== 8'h0A) begin errors++; $display("[TB] FAIL hold_edge3 got %h expected 0a", control_reg); end
        bus_d = 8'h55;
        repeat (17) tick();
        checks++; if (control_reg !== 8'h0A) begin errors++; $display("[TB] FAIL hold_single got %h expected 0a", control_reg); end
        bus_iow_l = 1'b1;
        repeat (4) tick();
        checks++; if (control_reg !== 8'h0A) begin errors++; $display("[TB] FAIL hold_release got %h expected 0a", control_reg); end
    endtask

    task automatic test_aen();
        bus_aen = 1'b1;
        io_write(15'h3D9, 8'h77);
        bus_aen = 1'b0;
        checks++; if (color_reg !== 8'h00) begin errors++; $display("[TB] FAIL aen_write got %h expected 00", color_reg); end
        io_write(15'h3D9, 8'h5A);
        checks++; if (color_reg !== 8'h5A) begin errors++; $display("[TB] FAIL color_write got %h expected 5a", color_reg); end
    endtask

    task automatic test_status();
        bus_a = 15'h3DA;
        bus_ior_l = 1'b0;
        #1;
        checks++; if ({bus_dir, bus_out} !== 9'h1F4) begin errors++; $display("[TB] FAIL status_idle got %h expected 1f4", {bus_dir, bus_out}); end
        vsync = 1'b1;
        display_enable = 1'b0;
        tick();
        checks++; if (bus_out !== 8'hF4) begin errors++; $display("[TB] FAIL status_1clk got %h expected f4", bus_out); end
        tick();
        checks++; if (bus_out !== 8'hFD) begin errors++; $display("[TB] FAIL status_2clk got %h expected fd", bus_out); end
        checks++; if (bus_dir !== 1'b1) begin errors++; $display("[TB] FAIL status_dir got %b expected 1", bus_dir); end
        bus_aen = 1'b1;
        #1;
        checks++; if ({bus_dir, bus_out} !== 9'h000) begin errors++; $display("[TB] FAIL status_aen got %h expected 000", {bus_dir, bus_out}); end
        bus_aen = 1'b0;
        bus_a = 15'h3D8;
        #1;
        checks++; if ({bus_dir, bus_out} !== 9'h000) begin errors++; $display("[TB] FAIL status_addr got %h expected 000", {bus_dir, bus_out}); end
        bus_a = 15'h3DA;
        bus_ior_l = 1'b1;
        #1;
        checks++; if ({bus_dir, bus_out} !== 9'h000) begin errors++; $display("[TB] FAIL status_noior got %h expected 000", {bus_dir, bus_out}); end
        repeat (4) tick();
    endtask

    task automatic test_wait();
        bit found;
        bit low_seen;
        int low_len;
        bus_mem_cs = 1'b1;
        bus_memr_l = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            tick();
            if (bus_rdy === 1'b0) found = 1'b1;
        end
        checks++; if (!found) begin errors++; $display("[TB] FAIL wait_start got rdy high expected low within 10 clocks"); end
        low_len = found ? 1 : 0;
        for (int i = 0; i < 20 && found; i++) begin
            tick();
            if (bus_rdy === 1'b0) low_len++;
            else break;
        end
        checks++; if (low_len !== 3) begin errors++; $display("[TB] FAIL wait_len got %0d expected 3", low_len); end
        low_seen = 1'b0;
        for (int i = 0; i < 5; i++) begin tick(); if (bus_rdy !== 1'b1) low_seen = 1'b1; end
        checks++; if (low_seen) begin errors++; $display("[TB] FAIL hold_rdy got low expected 1"); end
        bus_memr_l = 1'b1;
        repeat (4) tick();

        bus_memw_l = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            tick();
            if (bus_rdy === 1'b0) found = 1'b1;
        end
        checks++; if (!found) begin errors++; $display("[TB] FAIL wait2_start got rdy high expected low within 10 clocks"); end
        reset_l = 1'b0;
        tick();
        checks++; if (bus_rdy !== 1'b1) begin errors++; $display("[TB] FAIL reset_abort got %b expected 1", bus_rdy); end
        reset_l = 1'b1;
        low_seen = 1'b0;
        for (int i = 0; i < 6; i++) begin tick(); if (bus_rdy !== 1'b1) low_seen = 1'b1; end
        checks++; if (low_seen) begin errors++; $display("[TB] FAIL no_resume got low expected 1"); end
        bus_memw_l = 1'b1;
        repeat (4) tick();

        reset_l = 1'b0;
        bus_memr_l = 1'b0;
        repeat (4) tick();
        reset_l = 1'b1;
        low_seen = 1'b0;
        for (int i = 0; i < 6; i++) begin tick(); if (bus_rdy !== 1'b1) low_seen = 1'b1; end
        checks++; if (low_seen) begin errors++; $display("[TB] FAIL edge_in_reset got low expected 1"); end
        bus_memr_l = 1'b1;
        repeat (4) tick();

        bus_mem_cs = 1'b0;
        bus_memr_l = 1'b0;
        low_seen = 1'b0;
        for (int i = 0; i < 8; i++) begin tick(); if (bus_rdy !== 1'b1) low_seen = 1'b1; end
        checks++; if (low_seen) begin errors++; $display("[TB] FAIL no_cs got low expected 1"); end
        bus_memr_l = 1'b1;
        repeat (4) tick();
    endtask

    initial begin
        $display("[TB] starting cga_io_regs bench");
        test_reset();
        test_blink();
        test_palette();
        test_depth_boundary();
        test_ga_regs();
        test_addressing();
        test_hold_write();
        test_aen();
        test_status();
        test_wait();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
